snake_head_ctrl: RTL and testbench

//  Parametrised snake-head controller: turns four direction buttons into a

---
 rtl/snake_head_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_snake_head_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_head_ctrl.sv
// Snake-head controller: edge-detected direction buttons, reverse rejection,
// and a tick-driven head mover over a WIDTH x HEIGHT grid with IDLE/RUN/DEAD FSM.
// Optional two-entry heading queue enabled by defining SNAKE_DIR_QUEUE_EN.
module snake_head_ctrl #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned HEIGHT    = 8,
  parameter int unsigned XW        = 4,
  parameter int unsigned YW        = 4,
  parameter int unsigned START_X   = 0,
  parameter int unsigned START_Y   = 0,
  parameter int unsigned START_DIR = 0,
  parameter int unsigned WRAP      = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          btn_right,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [1:0]    dir,
  output logic          running,
  output logic          dead,
  output logic          moved
);

  localparam int unsigned XW1 = XW + 1;
  localparam int unsigned YW1 = YW + 1;

  localparam logic [XW1-1:0] X_LIM = XW1'(WIDTH);
  localparam logic [YW1-1:0] Y_LIM = YW1'(HEIGHT);
  localparam logic [XW-1:0]  X_RST = XW'(START_X);
  localparam logic [YW-1:0]  Y_RST = YW'(START_Y);
  localparam logic [1:0]     D_RST = 2'(START_DIR);

  localparam logic [1:0] D_RIGHT = 2'd0;
  localparam logic [1:0] D_DOWN  = 2'd1;
  localparam logic [1:0] D_LEFT  = 2'd2;
  localparam logic [1:0] D_UP    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  state_t state_q, state_d;

  // button vectors are ordered {up, right, down, left}
  logic [3:0] btn_now, btn_q, btn_edge;
  logic       req_vld;
  logic [1:0] req_dir;
  logic [1:0] mv_dir;
  logic [1:0] ref_dir;

  logic [XW1-1:0] nx;
  logic [YW1-1:0] ny;
  logic           off_grid;

  logic [XW-1:0] x_d;
  logic [YW-1:0] y_d;
  logic [1:0]    dir_d;
  logic          moved_d;
  logic          running_d;
  logic          dead_d;

`ifdef SNAKE_DIR_QUEUE_EN
  logic [1:0] q0_q, q1_q, q0_d, q1_d;
  logic [1:0] qn_q, qn_d;
`else
  logic [1:0] pend_q, pend_d;
`endif

  assign btn_now  = {btn_up, btn_right, btn_down, btn_left};
  assign btn_edge = btn_now & ~btn_q;

  // One request per cycle: up > right > down > left
  always_comb begin
    req_vld = |btn_edge;
    req_dir = D_LEFT;
    if (btn_edge[3])      req_dir = D_UP;
    else if (btn_edge[2]) req_dir = D_RIGHT;
    else if (btn_edge[1]) req_dir = D_DOWN;
  end

  // Heading used by a step taken this cycle
  always_comb begin
`ifdef SNAKE_DIR_QUEUE_EN
    mv_dir = (qn_q != 2'd0) ? q0_q : dir;
`else
    mv_dir = pend_q;
`endif
  end

  // Candidate next cell with one extra bit so edges are seen, not aliased
  always_comb begin
    nx       = {1'b0, x};
    ny       = {1'b0, y};
    off_grid = 1'b0;
    case (mv_dir)
      D_RIGHT: begin
        nx = {1'b0, x} + XW1'(1);
        if (nx >= X_LIM) begin
          off_grid = 1'b1;
          nx       = '0;
        end
      end
      D_LEFT: begin
        nx = {1'b0, x} - XW1'(1);
        if (nx[XW]) begin
          off_grid = 1'b1;
          nx       = X_LIM - XW1'(1);
        end
      end
      D_DOWN: begin
        ny = {1'b0, y} + YW1'(1);
        if (ny >= Y_LIM) begin
          off_grid = 1'b1;
          ny       = '0;
        end
      end
      default: begin
        ny = {1'b0, y} - YW1'(1);
        if (ny[YW]) begin
          off_grid = 1'b1;
          ny       = Y_LIM - YW1'(1);
        end
      end
    endcase
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    x_d     = x;
    y_d     = y;
    dir_d   = dir;
    moved_d = 1'b0;
    ref_dir = dir;
`ifdef SNAKE_DIR_QUEUE_EN
    q0_d = q0_q;
    q1_d = q1_q;
    qn_d = qn_q;
`else
    pend_d = pend_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_vld) begin
          dir_d   = req_dir;
`ifdef SNAKE_DIR_QUEUE_EN
          qn_d    = 2'd0;
`else
          pend_d  = req_dir;
`endif
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (step) begin
          dir_d = mv_dir;
`ifdef SNAKE_DIR_QUEUE_EN
          if (qn_q != 2'd0) begin
            q0_d = q1_q;
            qn_d = qn_q - 2'd1;
          end
`endif
          if (off_grid && (WRAP == 0)) begin
            state_d = S_DEAD;
          end else begin
            x_d     = nx[XW-1:0];
            y_d     = ny[YW-1:0];
            moved_d = 1'b1;
          end
        end

        // Requests are checked against the heading as it stands after this cycle's step
`ifdef SNAKE_DIR_QUEUE_EN
        if (qn_d == 2'd2)      ref_dir = q1_d;
        else if (qn_d == 2'd1) ref_dir = q0_d;
        else                   ref_dir = dir_d;
`else
        ref_dir = dir_d;
`endif
        if (req_vld && (req_dir != ref_dir) && (req_dir != (ref_dir ^ 2'd2))) begin
`ifdef SNAKE_DIR_QUEUE_EN
          if (qn_d == 2'd0) begin
            q0_d = req_dir;
            qn_d = 2'd1;
          end else if (qn_d == 2'd1) begin
            q1_d = req_dir;
            qn_d = 2'd2;
          end
`else
          pend_d = req_dir;
`endif
        end
      end

      default: begin
      end
    endcase

    running_d = (state_d == S_RUN);
    dead_d    = (state_d == S_DEAD);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      btn_q   <= '0;
      x       <= X_RST;
      y       <= Y_RST;
      dir     <= D_RST;
      running <= 1'b0;
      dead    <= 1'b0;
      moved   <= 1'b0;
`ifdef SNAKE_DIR_QUEUE_EN
      q0_q    <= D_RST;
      q1_q    <= D_RST;
      qn_q    <= 2'd0;
`else
      pend_q  <= D_RST;
`endif
    end else begin
      state_q <= state_d;
      btn_q   <= btn_now;
      x       <= x_d;
      y       <= y_d;
      dir     <= dir_d;
      running <= running_d;
      dead    <= dead_d;
      moved   <= moved_d;
`ifdef SNAKE_DIR_QUEUE_EN
      q0_q    <= q0_d;
      q1_q    <= q1_d;
      qn_q    <= qn_d;
`else
      pend_q  <= pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Bench for snake_head_ctrl: three configurations (wrap 16x8, wall 16x8,
// wrap 10x5) driven together and compared against a grid-level reference model.
module tb_snake_head_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic step;
  logic btn_up, btn_down, btn_left, btn_right;

  logic [3:0] ox [3];
  logic [3:0] oy [3];
  logic [1:0] od [3];
  logic       orun [3];
  logic       odead [3];
  logic       omov [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snake_head_ctrl dut_a (
    .clk(clk), .reset(reset), .step(step),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .x(ox[0]), .y(oy[0]), .dir(od[0]), .running(orun[0]), .dead(odead[0]), .moved(omov[0])
  );

  snake_head_ctrl #(.WRAP(0)) dut_b (
    .clk(clk), .reset(reset), .step(step),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .x(ox[1]), .y(oy[1]), .dir(od[1]), .running(orun[1]), .dead(odead[1]), .moved(omov[1])
  );

  snake_head_ctrl #(.WIDTH(10), .HEIGHT(5), .START_X(2), .START_Y(4), .START_DIR(3)) dut_c (
    .clk(clk), .reset(reset), .step(step),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .x(ox[2]), .y(oy[2]), .dir(od[2]), .running(orun[2]), .dead(odead[2]), .moved(omov[2])
  );

  // Reference model: heading 0=right 1=down 2=left 3=up; phase 0=idle 1=run 2=dead
  localparam int GW [3] = '{16, 16, 10};
  localparam int GH [3] = '{8, 8, 5};
  localparam int GWRAP [3] = '{1, 0, 1};
  localparam int SX [3] = '{0, 0, 2};
  localparam int SY [3] = '{0, 0, 4};
  localparam int SD [3] = '{0, 0, 3};
  localparam int DX [4] = '{1, 0, -1, 0};
  localparam int DY [4] = '{0, 1, 0, -1};

  int mx [3], my [3], md [3], mph [3], mpend [3], mmov [3];
  int mq [3][2];
  int mqn [3];
  bit [3:0] mprev;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mx[k] = SX[k]; my[k] = SY[k]; md[k] = SD[k]; mpend[k] = SD[k];
      mph[k] = 0; mmov[k] = 0; mqn[k] = 0;
    end
    mprev = '0;
  endtask

  task automatic model_cycle(input bit st, input bit [3:0] b);
    bit [3:0] e;
    int req, d, nx, ny, r;
    e = b & ~mprev;
    mprev = b;
    req = -1;
    if (e[3]) req = 3; else if (e[2]) req = 0; else if (e[1]) req = 1; else if (e[0]) req = 2;
    for (int k = 0; k < 3; k++) begin
      mmov[k] = 0;
      if (mph[k] == 0) begin
        if (req >= 0) begin md[k] = req; mpend[k] = req; mph[k] = 1; end
      end else if (mph[k] == 1) begin
        if (st) begin
`ifdef SNAKE_DIR_QUEUE_EN
          if (mqn[k] > 0) begin d = mq[k][0]; mq[k][0] = mq[k][1]; mqn[k]--; end
          else d = md[k];
`else
          d = mpend[k];
`endif
          md[k] = d;
          nx = mx[k] + DX[d];
          ny = my[k] + DY[d];
          if ((nx < 0 || nx >= GW[k] || ny < 0 || ny >= GH[k]) && GWRAP[k] == 0) begin
            mph[k] = 2;
          end else begin
            mx[k] = (nx + GW[k]) % GW[k];
            my[k] = (ny + GH[k]) % GH[k];
            mmov[k] = 1;
          end
        end
        if (req >= 0) begin
          r = md[k];
`ifdef SNAKE_DIR_QUEUE_EN
          if (mqn[k] > 0) r = mq[k][mqn[k]-1];
`endif
          if (req != r && req != (r + 2) % 4) begin
`ifdef SNAKE_DIR_QUEUE_EN
            if (mqn[k] < 2) begin mq[k][mqn[k]] = req; mqn[k]++; end
`else
            mpend[k] = req;
`endif
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s/dut%0d.x", tag, k),       32'(ox[k]),    mx[k]);
      chk($sformatf("%s/dut%0d.y", tag, k),       32'(oy[k]),    my[k]);
      chk($sformatf("%s/dut%0d.dir", tag, k),     32'(od[k]),    md[k]);
      chk($sformatf("%s/dut%0d.running", tag, k), 32'(orun[k]),  (mph[k] == 1) ? 1 : 0);
      chk($sformatf("%s/dut%0d.dead", tag, k),    32'(odead[k]), (mph[k] == 2) ? 1 : 0);
      chk($sformatf("%s/dut%0d.moved", tag, k),   32'(omov[k]),  mmov[k]);
    end
  endtask

  // Drive one cycle of inputs {up,right,down,left}, advance model, check after the edge
  task automatic cyc(input bit st, input bit [3:0] b, input string tag);
    step = st;
    {btn_up, btn_right, btn_down, btn_left} = b;
    model_cycle(st, b);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset mid-cycle; outputs must respond without a clock edge
  task automatic do_reset(input string tag);
    #2 reset = 1'b0;
    model_reset();
    #1 check_all({tag, "_async"});
    step = 1'b0;
    {btn_up, btn_right, btn_down, btn_left} = 4'b0000;
    @(posedge clk);
    #1;
    check_all({tag, "_held"});
    reset = 1'b1;
  endtask

  initial begin
    bit [3:0] rb;
    reset = 1'b1;
    step = 1'b0;
    {btn_up, btn_right, btn_down, btn_left} = 4'b0000;
    model_reset();
    #1 reset = 1'b0;
    #1 check_all("por");
    chk("por_x", 32'(ox[0]), 0);
    chk("por_run", 32'(orun[0]), 0);
    chk("por_c_y", 32'(oy[2]), 4);
    @(posedge clk);
    #1 reset = 1'b1;

    // Steps in IDLE do nothing; first edge starts the game
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0000, "idle_step");
    chk("idle_x", 32'(ox[0]), 0);
    chk("idle_moved", 32'(omov[0]), 0);
    cyc(1'b0, 4'b0100, "start");
    chk("start_running", 32'(orun[0]), 1);
    cyc(1'b0, 4'b0000, "start_rel");
    cyc(1'b1, 4'b0000, "first_step");
    chk("first_x", 32'(ox[0]), 1);
    chk("first_moved", 32'(omov[0]), 1);
    cyc(1'b0, 4'b0000, "after_step");
    chk("moved_pulse", 32'(omov[0]), 0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'b0000, "to_x5");
    chk("at_x5", 32'(ox[0]), 5);

    // Reset while running
    do_reset("midrun");
    chk("rst_x", 32'(ox[0]), 0);
    chk("rst_dir", 32'(od[0]), 0);

    // Reverse rejected; held button yields one request only
    cyc(1'b0, 4'b0100, "rev_start");
    cyc(1'b0, 4'b0000, "rev_rel");
    cyc(1'b0, 4'b0001, "rev_left");
    cyc(1'b0, 4'b0000, "rev_left_rel");
    cyc(1'b1, 4'b0000, "rev_step");
    chk("rev_x", 32'(ox[0]), 1);
    chk("rev_dir", 32'(od[0]), 0);
    for (int i = 0; i < 10; i++) begin
      rb = (i == 2) ? 4'b1100 : 4'b0100;
      cyc((i == 4 || i == 6 || i == 8), rb, "hold_right");
    end
    chk("hold_dir", 32'(od[0]), 3);
    chk("hold_y", 32'(oy[0]), 5);
    chk("hold_x", 32'(ox[0]), 1);
    chk("hold_b_dead", 32'(odead[1]), 1);
    cyc(1'b0, 4'b0000, "hold_rel");

    // Right edge: wrap on dut_a, death on dut_b
    do_reset("edge");
    cyc(1'b0, 4'b0100, "edge_start");
    cyc(1'b0, 4'b0000, "edge_rel");
    for (int i = 0; i < 15; i++) cyc(1'b1, 4'b0000, "to_x15");
    chk("x15_a", 32'(ox[0]), 15);
    chk("x15_b", 32'(ox[1]), 15);
    cyc(1'b1, 4'b0000, "edge_step");
    chk("wrap_x", 32'(ox[0]), 0);
    chk("wall_dead", 32'(odead[1]), 1);
    chk("wall_run", 32'(orun[1]), 0);
    chk("wall_x", 32'(ox[1]), 15);
    chk("wall_moved", 32'(omov[1]), 0);
    cyc(1'b0, 4'b1000, "up_edge");
    cyc(1'b0, 4'b0000, "up_rel");
    cyc(1'b1, 4'b0000, "up_step");
    chk("wrap_y", 32'(oy[0]), 7);
    chk("wrap_y_dir", 32'(od[0]), 3);
    cyc(1'b0, 4'b0010, "dead_btn");
    cyc(1'b1, 4'b0001, "dead_step");
    cyc(1'b1, 4'b1000, "dead_step2");
    chk("dead_hold_x", 32'(ox[1]), 15);
    chk("dead_hold_y", 32'(oy[1]), 0);
    chk("dead_hold", 32'(odead[1]), 1);

    // Two quick turns between ticks
    do_reset("uturn");
    cyc(1'b0, 4'b0100, "ut_start");
    cyc(1'b0, 4'b0000, "ut_rel");
    cyc(1'b1, 4'b0000, "ut_s1");
    cyc(1'b1, 4'b0000, "ut_s2");
    cyc(1'b0, 4'b1000, "ut_up");
    cyc(1'b0, 4'b0000, "ut_up_rel");
    cyc(1'b0, 4'b0001, "ut_left");
    cyc(1'b0, 4'b0000, "ut_left_rel");
    cyc(1'b1, 4'b0000, "ut_tick1");
    chk("ut1_y", 32'(oy[0]), 7);
    chk("ut1_x", 32'(ox[0]), 2);
    cyc(1'b1, 4'b0000, "ut_tick2");
`ifdef SNAKE_DIR_QUEUE_EN
    chk("ut2_x", 32'(ox[0]), 1);
    chk("ut2_y", 32'(oy[0]), 7);
`else
    chk("ut2_x", 32'(ox[0]), 2);
    chk("ut2_y", 32'(oy[0]), 6);
`endif

    // Randomised play with occasional resets
    rb = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset("rnd_rst");
      end else begin
        if ($urandom_range(0, 2) == 0) rb = 4'($urandom);
        else if ($urandom_range(0, 3) == 0) rb = 4'b0000;
        cyc($urandom_range(0, 2) == 0, rb, "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
